// File: rtl/data_bus_arbiter.sv
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : Two-master arbiter and sequencer for the shared external data
//            bus (asynchronous read, synchronous write). One transfer takes
//            IDLE -> XFER -> DONE. Read data is registered and a one-cycle
//            ack is returned to the owner of the transfer.
// Config   : BUS_ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//            BUS_ARB_ROUND_ROBIN_EN undefined -> fixed priority to master 0
//                                                 with MAX_HOLD starvation guard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              read,
    output logic              write,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nxt_state;

    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_any_req;
    logic              w_start;
    logic              w_grant1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Master granted most recently; resets to 1 so master 0 wins the first tie.
    logic              r_last;

    // Round-robin: on a tie the master that was not granted last wins.
    always_comb begin
        w_grant1 = m1_req & (~m0_req | ~r_last);
    end

    // Remember the last winner for the next tie-break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_start) begin
            r_last <= w_grant1;
        end
    end
`else
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);

    // Consecutive master-0 grants taken while master 1 was waiting.
    logic [c_HOLD_W-1:0] r_hold_cnt;

    // Fixed priority to master 0 unless master 1 has waited MAX_HOLD grants.
    always_comb begin
        w_grant1 = m1_req & (~m0_req | (r_hold_cnt == c_HOLD_MAX));
    end

    // Starvation guard: count m0 wins over a waiting m1, clear otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_start) begin
            if (!w_grant1 && m1_req) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end
`endif

    // Winner selection and next-state logic.
    always_comb begin
        w_any_req   = m0_req | m1_req;
        w_start     = 1'b0;
        w_sel_we    = w_grant1 ? m1_we    : m0_we;
        w_sel_addr  = w_grant1 ? m1_addr  : m0_addr;
        w_sel_wdata = w_grant1 ? m1_wdata : m0_wdata;
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_start     = 1'b1;
                    w_nxt_state = S_XFER;
                end
            end
            S_XFER:  w_nxt_state = S_DONE;
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Transfer latch, registered bus strobes, read capture and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_bus_addr <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle; they fall back to idle by default.
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_bus_addr <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            if (w_start) begin
                r_owner    <= w_grant1;
                r_we       <= w_sel_we;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_read     <= ~w_sel_we;
                r_write    <= w_sel_we;
                r_bus_addr <= w_sel_addr;
            end
            if (r_state == S_XFER) begin
                if (!r_we) begin
                    if (r_owner) begin
                        r_m1_rdata <= bus_data;
                    end else begin
                        r_m0_rdata <= bus_data;
                    end
                end
                r_m0_ack <= ~r_owner;
                r_m1_ack <= r_owner;
            end
        end
    end

    // Drive enable comes only from the registered write strobe.
    assign bus_data = r_write ? r_wdata : {DATA_W{1'bz}};

    assign bus_addr = r_bus_addr;
    assign read     = r_read;
    assign write    = r_write;
    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign owner    = r_owner;
    assign busy     = (r_state != S_IDLE);

    // Latched address is mirrored onto the bus strobe register at grant time.
    logic w_unused;
    assign w_unused = ^r_addr;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
// ============================================================================
// Module   : tb_data_bus_arbiter
// Purpose  : Scoreboard bench for data_bus_arbiter (MAX_HOLD = 2). Stimulus
//            pushes expected bus cycles and acks into queues; a monitor pops
//            and compares whenever the DUT shows a strobe or an ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [19:0] m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [19:0] bus_addr;
    logic        read, write, owner, busy;
    wire  [15:0] bus_data;

    logic [15:0] mem [0:31];
    logic        probe_en;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_bus_cyc = -10;

    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [15:0] data;
    } bus_t;

    typedef struct packed {
        logic        port;
        logic        chk;
        logic [15:0] data;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];

    data_bus_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_addr(bus_addr), .read(read), .write(write), .bus_data(bus_data),
        .owner(owner), .busy(busy)
    );

    // Slave: combinational read; a probe pattern shows whether the DUT is off the bus.
    assign bus_data = read ? mem[bus_addr[4:0]] : (probe_en ? 16'hA5A5 : 16'hzzzz);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (write) mem[bus_addr[4:0]] <= bus_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_rd(input bit port, input logic [19:0] addr);
        bus_t b;
        ack_t a;
        b.we = 1'b0; b.addr = addr; b.data = mem[addr[4:0]];
        a.port = port; a.chk = 1'b1; a.data = mem[addr[4:0]];
        exp_bus.push_back(b);
        exp_ack.push_back(a);
    endtask

    task automatic exp_wr(input bit port, input logic [19:0] addr, input logic [15:0] data);
        bus_t b;
        ack_t a;
        b.we = 1'b1; b.addr = addr; b.data = data;
        a.port = port; a.chk = 1'b0; a.data = 16'h0;
        exp_bus.push_back(b);
        exp_ack.push_back(a);
    endtask

    // One master transfer: raise req, wait (bounded) for ack, drop after the ack edge.
    task automatic xfer(input bit m, input bit we, input logic [19:0] addr, input logic [15:0] wd);
        int n;
        if (m == 1'b0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m ? m1_ack : m0_ack) && n < 50);
        check(m ? "m1_ack_timeout" : "m0_ack_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (m == 1'b0) m0_req = 1'b0;
        else           m1_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every strobe cycle and every ack must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (read || write) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_bus_cycle", {11'd0, write, bus_addr}, 32'hFFFFFFFF);
                end else begin
                    bus_t b;
                    b = exp_bus.pop_front();
                    check("bus_write", {31'd0, write}, {31'd0, b.we});
                    check("bus_read", {31'd0, read}, {31'd0, ~b.we});
                    check("bus_addr", {12'd0, bus_addr}, {12'd0, b.addr});
                    check("bus_data", {16'd0, bus_data}, {16'd0, b.data});
                end
                last_bus_cyc = cyc;
            end
            if (m0_ack || m1_ack) begin
                check("ack_onehot", {31'd0, m0_ack & m1_ack}, 32'd0);
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
                end else begin
                    ack_t a;
                    a = exp_ack.pop_front();
                    check("ack_port", {31'd0, m1_ack}, {31'd0, a.port});
                    check("ack_owner", {31'd0, owner}, {31'd0, a.port});
                    check("ack_latency", cyc, last_bus_cyc + 1);
                    if (a.chk) begin
                        check(a.port ? "m1_rdata" : "m0_rdata",
                              {16'd0, (a.port ? m1_rdata : m0_rdata)}, {16'd0, a.data});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        probe_en = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_bus_addr", {12'd0, bus_addr}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back through master 0.
        exp_wr(1'b0, 20'h00010, 16'hBEEF);
        xfer(1'b0, 1'b1, 20'h00010, 16'hBEEF);
        check("mem_after_write", {16'd0, mem[16]}, 32'h0000BEEF);
        exp_rd(1'b0, 20'h00010);
        xfer(1'b0, 1'b0, 20'h00010, 16'h0);

        // Simultaneous reads: master 0 first, then master 1.
        apply_reset();
        exp_rd(1'b0, 20'h5);
        exp_rd(1'b1, 20'h6);
        fork
            xfer(1'b0, 1'b0, 20'h5, 16'h0);
            xfer(1'b1, 1'b0, 20'h6, 16'h0);
        join

        // Continuous contention.
        apply_reset();
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_rd(1'b0, 20'h1); exp_rd(1'b1, 20'h7); exp_rd(1'b0, 20'h2);
        exp_rd(1'b1, 20'h8); exp_rd(1'b0, 20'h3); exp_rd(1'b0, 20'h4);
        exp_rd(1'b0, 20'h5);
`else
        exp_rd(1'b0, 20'h1); exp_rd(1'b0, 20'h2); exp_rd(1'b1, 20'h7);
        exp_rd(1'b0, 20'h3); exp_rd(1'b0, 20'h4); exp_rd(1'b1, 20'h8);
        exp_rd(1'b0, 20'h5);
`endif
        fork
            begin
                for (int i = 1; i <= 5; i++) xfer(1'b0, 1'b0, 20'(i), 16'h0);
            end
            begin
                xfer(1'b1, 1'b0, 20'h7, 16'h0);
                xfer(1'b1, 1'b0, 20'h8, 16'h0);
            end
        join

        // Reset in the middle of a master-1 write: no ack, strobe drops at once.
        begin
            bus_t b;
            b.we = 1'b1; b.addr = 20'h3; b.data = 16'h1234;
            exp_bus.push_back(b);
        end
        m1_we = 1'b1; m1_addr = 20'h3; m1_wdata = 16'h1234; m1_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!write && n < 20);
        check("abort_write_seen", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_write_low", {31'd0, write}, 32'd0);
        check("abort_read_low", {31'd0, read}, 32'd0);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        check("abort_no_ack", {31'd0, m1_ack}, 32'd0);
        m1_req = 1'b0;
        m1_we = 1'b0;
        probe_en = 1'b1;
        #1;
        check("abort_bus_data_z", {16'd0, bus_data}, 32'h0000A5A5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ten idle cycles with no requests.
        repeat (10) begin
            @(negedge clk);
            check("idle_read", {31'd0, read}, 32'd0);
            check("idle_write", {31'd0, write}, 32'd0);
            check("idle_bus_addr", {12'd0, bus_addr}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_bus_data_z", {16'd0, bus_data}, 32'h0000A5A5);
        end
        probe_en = 1'b0;
        check("abort_mem_untouched", {16'd0, mem[3]}, 32'h00001003);

        // Aborted write left memory alone; a new read is served normally.
        exp_rd(1'b0, 20'h3);
        xfer(1'b0, 1'b0, 20'h3, 16'h0);

        n = 0;
        while ((exp_bus.size() != 0 || exp_ack.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("exp_bus_drained", exp_bus.size(), 32'd0);
        check("exp_ack_drained", exp_ack.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter and sequencer for the shared external data-memory bus (16-bit data, 20-bit address, asynchronous read, synchronous write).
- Grants the bus to either the pipeline load/store port (master 0) or a secondary master (master 1, e.g. DMA or debug).
- Drives `bus_addr`, `read`, `write` and `bus_data`, registers read data, and returns a one-cycle `ack` to the owner.
- Sits between the requesters and every memory/peripheral slave on the bus.

## Interface
- `ADDR_W`, 20: bus address width.
- `DATA_W`, 16: bus data width.
- `MAX_HOLD`, 8: maximum consecutive grants to master 0 while master 1 waits (fixed-priority mode); must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  transfer request; held high until `ack` is sampled.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `m0_addr`, `m1_addr`  in  ADDR_W  transfer address; stable while `req` is high.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; stable while `req` is high.
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data; valid when `ack` is high, then held.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `bus_addr`  out  ADDR_W  bus address.
- `read`  out  1  bus read strobe.
- `write`  out  1  bus write strobe.
- `bus_data`  inout  DATA_W  driven only during a write transfer; `z` otherwise.
- `owner`  out  1  master currently granted; valid while `busy` is high.
- `busy`  out  1  high in XFER and DONE.

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE:**
  - If any `req` is high, arbitrate at the edge and register the result into `owner`.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers, then go to XFER.
  - With no request, remain in IDLE.
- **XFER (one cycle):**
  - `bus_addr` = latched address.
  - `read` = ~we and `write` = we.
  - `bus_data` is driven with the latched wdata only when we = 1.
  - At the closing edge, a read captures `bus_data` into the owner's `rdata`; the slave performs a write on the same edge. Then go to DONE.
- **DONE (one cycle):**
  - Owner's `ack` = 1; bus idle.
  - Always go to IDLE next.
  - The master updates or drops `req`/`addr`/`we`/`wdata` at the edge where it samples `ack`.
- **Bus idle values (IDLE and DONE):** `bus_addr` = 0, `read` = 0, `write` = 0, `bus_data` = z.
- **Arbitration:** fixed priority to master 0, with starvation guard `hold_cnt` (width clog2(MAX_HOLD+1)).
  - `hold_cnt` increments on each grant to master 0 while `m1_req` is high.
  - `hold_cnt` clears on any grant to master 1, or on a master-0 grant while `m1_req` is low.
  - When `hold_cnt` == MAX_HOLD and `m1_req` is high, master 1 wins regardless of `m0_req`.
- A request arriving while the bus is busy waits; only levels sampled in IDLE matter.
- A master that drops `req` before `ack` (protocol violation) does not abort the transfer; `ack` is still issued.
- Reset (any time, including mid-XFER) forces:
  - IDLE, `hold_cnt` = 0, `owner` = 0, `busy` = 0;
  - both `ack` = 0, both `rdata` = 0;
  - `read` = `write` = 0 and `bus_data` = z, asynchronously.
  - No `ack` is ever issued for an aborted transfer.

## Timing
- Request first sampled high at edge E: bus active in cycle E..E+1; `ack` high in cycle E+1..E+2; earliest next arbitration at edge E+3.
- Throughput: one transfer per 3 cycles.
- Strobes are glitch-free registered outputs; `bus_data` drive enable comes from registered state only.
- Read data is captured at the end of XFER; the slave's combinational read path must settle within one cycle.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined:
  - When both masters request in IDLE, the master not granted last wins.
  - A single requester always wins.
  - `hold_cnt` and `MAX_HOLD` are unused and `hold_cnt` stays 0.
- Undefined: fixed priority with the MAX_HOLD starvation guard as above.

## Test plan
- Reset, then m0 write addr 0x00010 data 0xBEEF: `write` = 1 and `bus_addr` = 0x00010 for exactly one cycle, `bus_data` = 0xBEEF in that cycle, `m0_ack` one cycle later. A following m0 read of 0x00010 returns `m0_rdata` = 0xBEEF with `m0_ack`.
- Simultaneous reads: m0 addr 0x5, m1 addr 0x6. Fixed mode: m0 served first, then m1, each `ack` on its own port; `m1_rdata` = mem[6].
- m0 and m1 requesting continuously with MAX_HOLD = 2, fixed mode: grant sequence m0, m0, m1, m0, m0, m1.
- Same stimulus with `BUS_ARB_ROUND_ROBIN_EN`: grant sequence m0, m1, m0, m1.
- Assert `rst_n` = 0 mid-XFER of an m1 write: `write` drops immediately, `bus_data` = z, no `m1_ack`, `busy` = 0; after release the FSM idles until a new `req`.
- No requests for 10 cycles: `read` = `write` = 0, `bus_addr` = 0, `bus_data` = z, `busy` = 0 throughout.
